// File: rtl/hand_pkg.sv
// Shared types and constants for the hand collector and its insertion helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hand_pkg;

  // Default geometry: five-card hands of 4-bit ranks (A=1 .. K=13).
  localparam int RANK_W    = 4;
  localparam int HAND_SIZE = 5;

  // Card counter width; wide enough for the largest hand (8 cards).
  localparam int CNT_W = 4;

  typedef logic [RANK_W-1:0] rank_t;
  typedef logic [CNT_W-1:0]  count_t;

  localparam rank_t RANK_MIN = rank_t'(1);
  localparam rank_t RANK_MAX = rank_t'(13);

  // FILL collects cards, PRESENT holds a complete hand for the detector.
  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Zero and 14/15 are not card ranks; zero doubles as the empty-slot marker.
  function automatic logic rank_is_legal(input rank_t r);
    return (r >= RANK_MIN) && (r <= RANK_MAX);
  endfunction

endpackage

// File: rtl/rank_insert.sv
// Sorted insertion of one new rank into the ascending slot vector of a partial hand.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is written back.
module rank_insert #(
  parameter int HAND_SIZE = hand_pkg::HAND_SIZE,
  parameter int RANK_W    = hand_pkg::RANK_W
) (
  input  logic [HAND_SIZE*RANK_W-1:0] slots_in,
  input  hand_pkg::count_t            count,
  input  logic [RANK_W-1:0]           rank,
  output logic [HAND_SIZE*RANK_W-1:0] slots_out
);

  logic [RANK_W-1:0] held [HAND_SIZE];
  logic [RANK_W-1:0] ins  [HAND_SIZE];
  int                pos;

  // Unpack the held slots and find the insertion point: after every held rank <= new rank,
  // which keeps equal ranks in arrival order.
  always_comb begin
    pos = 0;
    for (int i = 0; i < HAND_SIZE; i++) begin
      held[i] = slots_in[i*RANK_W +: RANK_W];
      if ((i < int'(count)) && (held[i] <= rank)) begin
        pos = pos + 1;
      end
    end
  end

  // Build the new vector: below pos unchanged, the new rank at pos, held ranks shifted up
  // by one up to the old count, empty slots above that untouched (still zero).
  always_comb begin
    ins[0] = (pos == 0) ? rank : held[0];
    for (int i = 1; i < HAND_SIZE; i++) begin
      if (i < pos) begin
        ins[i] = held[i];
      end else if (i == pos) begin
        ins[i] = rank;
      end else if (i <= int'(count)) begin
        ins[i] = held[i-1];
      end else begin
        ins[i] = held[i];
      end
    end
  end

  // Repack into the flat slot vector, slot i at bits [i*RANK_W +: RANK_W].
  always_comb begin
    slots_out = '0;
    for (int i = 0; i < HAND_SIZE; i++) begin
      slots_out[i*RANK_W +: RANK_W] = ins[i];
    end
  end

endmodule

// File: rtl/hand_collector.sv
// Collects legal card ranks into a hand and presents it in parallel to the detector.
// Latency: card_count updates the edge after accept; hand_valid rises the cycle after the last card.
// Backpressure: card_ready=0 while a hand is presented; the hand is held until hand_ready.
// Build option HAND_COLLECTOR_SORT_EN: store each hand in ascending rank order (stable).
module hand_collector #(
  parameter int HAND_SIZE = hand_pkg::HAND_SIZE,
  parameter int RANK_W    = hand_pkg::RANK_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        card_valid,
  input  logic [RANK_W-1:0]           card_rank,
  output logic                        card_ready,
  input  logic                        flush,
  output logic                        hand_valid,
  output logic [HAND_SIZE*RANK_W-1:0] hand_ranks,
  input  logic                        hand_ready,
  output logic [2:0]                  card_count,
  output logic                        err_rank
);

  import hand_pkg::*;

  localparam count_t FULL = count_t'(HAND_SIZE);

  state_t                      state;
  count_t                      count;
  logic [HAND_SIZE*RANK_W-1:0] slots;
  logic [HAND_SIZE*RANK_W-1:0] slots_next;
  logic                        legal;

  assign legal      = rank_is_legal(card_rank);
  assign card_ready = (state == FILL);
  assign hand_ranks = slots;
  // The port is 3 bits wide; a full 8-card hand is signalled by hand_valid rather than the count.
  assign card_count = count[2:0];

`ifdef HAND_COLLECTOR_SORT_EN
  // Held slots are always sorted, so inserting keeps the whole hand sorted.
  rank_insert #(
    .HAND_SIZE (HAND_SIZE),
    .RANK_W    (RANK_W)
  ) u_rank_insert (
    .slots_in  (slots),
    .count     (count),
    .rank      (card_rank),
    .slots_out (slots_next)
  );
`else
  // Append path: the new rank lands in the first empty slot, arrival order preserved.
  always_comb begin
    slots_next = slots;
    for (int i = 0; i < HAND_SIZE; i++) begin
      if (count == count_t'(i)) begin
        slots_next[i*RANK_W +: RANK_W] = card_rank;
      end
    end
  end
`endif

  // Collector FSM with registered outputs; flush overrides any same-cycle card or hand transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      count      <= '0;
      slots      <= '0;
      hand_valid <= 1'b0;
      err_rank   <= 1'b0;
    end else begin
      err_rank <= 1'b0;
      if (flush) begin
        state      <= FILL;
        count      <= '0;
        slots      <= '0;
        hand_valid <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (card_valid) begin
              if (legal) begin
                slots <= slots_next;
                count <= count + 1'b1;
                if ((count + 1'b1) == FULL) begin
                  state      <= PRESENT;
                  hand_valid <= 1'b1;
                end
              end else begin
                err_rank <= 1'b1;
              end
            end
          end
          PRESENT: begin
            if (hand_ready) begin
              state      <= FILL;
              count      <= '0;
              slots      <= '0;
              hand_valid <= 1'b0;
            end
          end
          default: begin
            state      <= FILL;
            count      <= '0;
            slots      <= '0;
            hand_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hand_collector.sv
// Directed bench for hand_collector: queue-based hand model checked every cycle,
// plus hand-computed literal hands for each scenario (both arrival and sorted builds).
module tb_hand_collector;

  localparam int HS = 5;
  localparam int RW = 4;

`ifdef HAND_COLLECTOR_SORT_EN
  localparam logic [HS*RW-1:0] EXP_T1 = 20'hC7331;
  localparam logic [HS*RW-1:0] EXP_T2 = 20'hD9542;
  localparam logic [HS*RW-1:0] EXP_T3 = 20'hDD711;
  localparam logic [HS*RW-1:0] EXP_T4 = 20'h65432;
`else
  localparam logic [HS*RW-1:0] EXP_T1 = 20'h1C373;
  localparam logic [HS*RW-1:0] EXP_T2 = 20'hD4952;
  localparam logic [HS*RW-1:0] EXP_T3 = 20'h71D1D;
  localparam logic [HS*RW-1:0] EXP_T4 = 20'h23456;
`endif
  localparam logic [HS*RW-1:0] EXP_T6A = 20'h54321;
  localparam logic [HS*RW-1:0] EXP_T6B = 20'hA9876;

  logic clk = 1'b0;
  logic rst;
  logic card_valid;
  logic [RW-1:0] card_rank;
  logic card_ready;
  logic flush;
  logic hand_valid;
  logic [HS*RW-1:0] hand_ranks;
  logic hand_ready;
  logic [2:0] card_count;
  logic err_rank;

  always #5 clk = ~clk;

  hand_collector #(.HAND_SIZE(HS), .RANK_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_ready (card_ready),
    .flush      (flush),
    .hand_valid (hand_valid),
    .hand_ranks (hand_ranks),
    .hand_ready (hand_ready),
    .card_count (card_count),
    .err_rank   (err_rank)
  );

  int total = 0;
  int bad = 0;

  // Model state: the legal cards held so far, whether a hand is on offer, and a transfer log.
  int held[$];
  bit presenting = 1'b0;
  bit exp_err = 1'b0;
  int cyc = 0;
  logic [HS*RW-1:0] xfer_hand[$];
  int xfer_cyc[$];
  int err_seen = 0;

  function automatic logic [HS*RW-1:0] pack_hand(input int q[$]);
    int s[$];
    logic [HS*RW-1:0] v;
    s = q;
`ifdef HAND_COLLECTOR_SORT_EN
    s.sort();
`endif
    v = '0;
    foreach (s[i]) v[i*RW +: RW] = RW'(s[i]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs presented during the cycle.
  always @(posedge clk) begin
    int r;
    cyc++;
    exp_err = 1'b0;
    r = int'(card_rank);
    if (rst === 1'b1 || flush === 1'b1) begin
      held.delete();
      presenting = 1'b0;
    end else if (!presenting) begin
      if (card_valid === 1'b1) begin
        if (r >= 1 && r <= 13) begin
          held.push_back(r);
          if (held.size() == HS) presenting = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
    end else if (hand_ready === 1'b1) begin
      xfer_hand.push_back(pack_hand(held));
      xfer_cyc.push_back(cyc);
      held.delete();
      presenting = 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the edge.
  always @(posedge clk) begin
    #2;
    chk("card_ready", 64'(card_ready), 64'(!presenting));
    chk("hand_valid", 64'(hand_valid), 64'(presenting));
    chk("card_count", 64'(card_count), 64'(held.size()));
    chk("err_rank", 64'(err_rank), 64'(exp_err));
    chk("hand_ranks", 64'(hand_ranks), 64'(pack_hand(held)));
    if (err_rank === 1'b1) err_seen++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      card_valid = 1'b0;
      flush = 1'b0;
    end
  endtask

  // Offer one card and hold it until the collector is ready; it is taken at the next edge.
  task automatic send(input int r);
    int n;
    @(negedge clk);
    card_valid = 1'b1;
    card_rank = RW'(r);
    flush = 1'b0;
    n = 0;
    while (card_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("card_ready_wait", 64'(card_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int e0;
    rst = 1'b1;
    card_valid = 1'b0;
    card_rank = '0;
    flush = 1'b0;
    hand_ready = 1'b1;
    repeat (2) @(negedge clk);
    // Reset values
    chk("rst_card_ready", 64'(card_ready), 64'd1);
    chk("rst_hand_valid", 64'(hand_valid), 64'd0);
    chk("rst_card_count", 64'(card_count), 64'd0);
    chk("rst_hand_ranks", 64'(hand_ranks), 64'd0);
    chk("rst_err_rank", 64'(err_rank), 64'd0);
    rst = 1'b0;

    // 1: basic hand 3,7,3,12,1 with hand_ready high
    send(3); send(7); send(3); send(12); send(1);
    @(posedge clk); #1;
    chk("t1_hand_valid", 64'(hand_valid), 64'd1);
    chk("t1_hand_ranks", 64'(hand_ranks), 64'(EXP_T1));
    idle(1);
    @(posedge clk); #1;
    chk("t1_count_after", 64'(card_count), 64'd0);
    chk("t1_valid_after", 64'(hand_valid), 64'd0);

    // 2: illegal ranks 0 and 15 mixed into five legal cards
    e0 = err_seen;
    send(2); send(0); send(5); send(9); send(15); send(4); send(13);
    @(posedge clk); #1;
    chk("t2_hand_valid", 64'(hand_valid), 64'd1);
    chk("t2_hand_ranks", 64'(hand_ranks), 64'(EXP_T2));
    idle(3);
    chk("t2_err_pulses", 64'(err_seen - e0), 64'd2);

    // 3: detector stalls for 10 cycles while cards are offered
    hand_ready = 1'b0;
    send(13); send(1); send(13); send(1); send(7);
    @(posedge clk); #1;
    chk("t3_hand_valid", 64'(hand_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      card_valid = 1'b1;
      card_rank = 4'd4;
    end
    @(posedge clk); #1;
    chk("t3_hand_ranks", 64'(hand_ranks), 64'(EXP_T3));
    chk("t3_card_ready", 64'(card_ready), 64'd0);
    chk("t3_card_count", 64'(card_count), 64'd5);
    @(negedge clk);
    card_valid = 1'b0;
    hand_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_released", 64'(hand_valid), 64'd0);

    // 4: flush after three cards, colliding with a fourth
    send(2); send(3); send(4);
    @(negedge clk);
    card_valid = 1'b1;
    card_rank = 4'd6;
    flush = 1'b1;
    @(posedge clk); #1;
    chk("t4_count_flush", 64'(card_count), 64'd0);
    chk("t4_no_err", 64'(err_rank), 64'd0);
    chk("t4_ranks_clear", 64'(hand_ranks), 64'd0);
    send(6); send(5); send(4); send(3); send(2);
    @(posedge clk); #1;
    chk("t4_hand_ranks", 64'(hand_ranks), 64'(EXP_T4));
    idle(2);

    // 5: reset while presenting
    hand_ready = 1'b0;
    send(1); send(2); send(3); send(4); send(5);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_hand_valid", 64'(hand_valid), 64'd0);
    chk("t5_card_count", 64'(card_count), 64'd0);
    chk("t5_card_ready", 64'(card_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    hand_ready = 1'b1;

    // 6: continuous stream of ten cards, two hands six cycles apart
    base = xfer_hand.size();
    for (int i = 1; i <= 10; i++) send(i);
    idle(3);
    chk("t6_hands", 64'(xfer_hand.size() - base), 64'd2);
    if (xfer_hand.size() >= base + 2) begin
      chk("t6_hand_a", 64'(xfer_hand[base]), 64'(EXP_T6A));
      chk("t6_hand_b", 64'(xfer_hand[base+1]), 64'(EXP_T6B));
      chk("t6_period", 64'(xfer_cyc[base+1] - xfer_cyc[base]), 64'd6);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
